// File: rtl/ifq_pkg.sv
// Shared fetch-controller definitions: FSM state encoding and cache-line geometry.
package ifq_pkg;

  localparam int unsigned WORDS_PER_LINE   = 4;
  localparam int unsigned LINE_OFFSET_BITS = 4;
  localparam int unsigned BEAT_BITS        = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Cache lookup/refill and memory word-request bus between fetch_ctrl and its memories.
interface fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]       cache_addr;
  logic                        cache_hit;
  logic [CACHE_LINE_WIDTH-1:0] cache_line;
  logic                        cache_we;
  logic [CACHE_LINE_WIDTH-1:0] cache_wline;
  logic                        mem_req;
  logic [DATA_WIDTH-1:0]       mem_addr;
  logic                        mem_ack;
  logic [DATA_WIDTH-1:0]       mem_data;

  modport master (
    output cache_addr, cache_we, cache_wline, mem_req, mem_addr,
    input  cache_hit, cache_line, mem_ack, mem_data
  );

  modport slave (
    input  cache_addr, cache_we, cache_wline, mem_req, mem_addr,
    output cache_hit, cache_line, mem_ack, mem_data
  );
endinterface

// File: rtl/fetch_ctrl_refill_buffer.sv
// Assembles a cache line from sequential memory words; beat counts the words received.
module refill_buffer
  import ifq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        load,
  input  logic [DATA_WIDTH-1:0]       word,
  output logic [BEAT_BITS-1:0]        beat,
  output logic                        last_beat,
  output logic [CACHE_LINE_WIDTH-1:0] line
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat <= '0;
      line <= '0;
    end else if (load) begin
      beat <= beat + BEAT_BITS'(1);
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
        if (beat == BEAT_BITS'(i)) begin
          line[i*DATA_WIDTH +: DATA_WIDTH] <= word;
        end
      end
    end
  end

  assign last_beat = (beat == BEAT_BITS'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: I-cache lookup, word-by-word refill on miss, and
// line delivery to the IFQ with redirect (flush) suppression of stale lines.
module fetch_ctrl
  import ifq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       pc_in,
  input  logic                        ifq_ready,
  input  logic                        flush,
  fetch_ctrl_if.master                bus,
  output logic [CACHE_LINE_WIDTH-1:0] D_out,
  output logic                        d_out_valid,
  output logic                        busy
);

  localparam logic [DATA_WIDTH-1:0] LINE_MASK =
    {{(DATA_WIDTH - LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  fetch_state_t state, next_state;

  logic [DATA_WIDTH-1:0]       line_addr;
  logic                        abort_pending;
  logic                        accept;
  logic                        refill_start;
  logic                        refill_load;
  logic [BEAT_BITS-1:0]        beat;
  logic                        last_beat;
  logic [CACHE_LINE_WIDTH-1:0] refill_line;

  assign accept       = ifq_ready && !flush;
  assign refill_start = (state == LOOKUP) && !flush && !bus.cache_hit;
  assign refill_load  = (state == REFILL) && bus.mem_ack;

  refill_buffer #(
    .DATA_WIDTH       (DATA_WIDTH),
    .CACHE_LINE_WIDTH (CACHE_LINE_WIDTH)
  ) u_refill_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (refill_start),
    .load      (refill_load),
    .word      (bus.mem_data),
    .beat      (beat),
    .last_beat (last_beat),
    .line      (refill_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      line_addr     <= '0;
      abort_pending <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && accept) begin
        line_addr <= pc_in & LINE_MASK;
      end
      if (refill_start) begin
        abort_pending <= 1'b0;
      end else if (((state == REFILL) || (state == WRITE)) && flush) begin
        abort_pending <= 1'b1;
      end
    end
  end

  assign bus.cache_addr = line_addr;
  assign busy           = (state != IDLE) && !rst;

  always_comb begin
    next_state      = state;
    bus.mem_req     = 1'b0;
    bus.mem_addr    = '0;
    bus.cache_we    = 1'b0;
    bus.cache_wline = '0;
    D_out           = '0;
    d_out_valid     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) next_state = LOOKUP;
      end
      LOOKUP: begin
        if (flush) begin
          next_state = IDLE;
        end else if (bus.cache_hit) begin
          D_out       = bus.cache_line;
          d_out_valid = 1'b1;
          next_state  = IDLE;
        end else begin
          next_state = REFILL;
        end
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = line_addr + (DATA_WIDTH'(beat) << 2);
        if (bus.mem_ack && last_beat) next_state = WRITE;
      end
      WRITE: begin
        bus.cache_we    = 1'b1;
        bus.cache_wline = refill_line;
        D_out           = refill_line;
        // A redirect arriving in this very cycle also makes the line stale.
        d_out_valid     = !abort_pending && !flush;
        next_state      = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // Outputs are held quiet for the whole reset window, even before the first edge.
    if (rst) begin
      bus.mem_req     = 1'b0;
      bus.mem_addr    = '0;
      bus.cache_we    = 1'b0;
      bus.cache_wline = '0;
      D_out           = '0;
      d_out_valid     = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed and randomized hit/miss/flush/reset scenarios.
module tb_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_in;
  logic         ifq_ready;
  logic         flush;
  logic [127:0] d_out;
  logic         d_out_valid;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.DATA_WIDTH(32), .CACHE_LINE_WIDTH(128)) bus ();

  fetch_ctrl #(.DATA_WIDTH(32), .CACHE_LINE_WIDTH(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .ifq_ready   (ifq_ready),
    .flush       (flush),
    .bus         (bus),
    .D_out       (d_out),
    .d_out_valid (d_out_valid),
    .busy        (busy)
  );

  // Reference model: a line starts at the 16-byte boundary at or below pc,
  // word k lives at line start + 4k, and the line is word 0 in the low bits.
  function automatic logic [31:0] align(input logic [31:0] pc);
    return pc - (pc % 32'd16);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] pc, input int k);
    return align(pc) + 32'(4 * k);
  endfunction

  function automatic logic [127:0] build_line(input logic [31:0] w [4]);
    logic [127:0] l = '0;
    for (int k = 0; k < 4; k++) l = l | (128'(w[k]) << (32 * k));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_mem_req"}, bus.mem_req, 1'b0);
    chk({tag, "_cache_we"}, bus.cache_we, 1'b0);
    chk({tag, "_dv"}, d_out_valid, 1'b0);
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [127:0] line);
    pc_in = pc; ifq_ready = 1'b1; flush = 1'b0;
    bus.cache_hit = 1'b1; bus.cache_line = line;
    step();
    ifq_ready = 1'b0;
    #1;
    chk("hit_cache_addr", bus.cache_addr, align(pc));
    chk("hit_dv", d_out_valid, 1'b1);
    chk("hit_d_out", d_out, line);
    chk("hit_busy", busy, 1'b1);
    step();
    chk_quiet("hit_after");
  endtask

  task automatic do_miss(input logic [31:0] pc, input logic [31:0] w [4],
                         input int stall, input int flush_beat);
    logic [127:0] exp_line;
    exp_line = build_line(w);
    pc_in = pc; ifq_ready = 1'b1; flush = 1'b0;
    bus.cache_hit = 1'b0; bus.mem_ack = 1'b0;
    step();
    ifq_ready = 1'b0;
    #1;
    chk("miss_lookup_addr", bus.cache_addr, align(pc));
    chk("miss_lookup_dv", d_out_valid, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < stall; s++) begin
        bus.mem_ack = 1'b0;
        #1;
        chk("stall_mem_req", bus.mem_req, 1'b1);
        chk("stall_mem_addr", bus.mem_addr, word_addr(pc, k));
        step();
      end
      bus.mem_ack = 1'b1; bus.mem_data = w[k]; flush = (k == flush_beat);
      #1;
      chk("ack_mem_req", bus.mem_req, 1'b1);
      chk("ack_mem_addr", bus.mem_addr, word_addr(pc, k));
      chk("ack_cache_we", bus.cache_we, 1'b0);
      step();
      bus.mem_ack = 1'b0; flush = 1'b0;
    end
    #1;
    chk("write_cache_we", bus.cache_we, 1'b1);
    chk("write_wline", bus.cache_wline, exp_line);
    chk("write_d_out", d_out, exp_line);
    chk("write_dv", d_out_valid, (flush_beat < 0) ? 1'b1 : 1'b0);
    chk("write_mem_req", bus.mem_req, 1'b0);
    step();
    chk_quiet("miss_after");
  endtask

  initial begin
    logic [31:0] w [4];
    rst = 1'b1; pc_in = '0; ifq_ready = 1'b0; flush = 1'b0;
    bus.cache_hit = 1'b0; bus.cache_line = '0; bus.mem_ack = 1'b0; bus.mem_data = '0;

    #1;
    chk_quiet("reset_pre_edge");
    chk("reset_pre_edge_d_out", d_out, '0);
    step(); step();
    chk_quiet("reset");
    chk("reset_d_out", d_out, '0);
    chk("reset_cache_addr", bus.cache_addr, '0);
    rst = 1'b0;
    step();

    do_hit(32'h0000_0104, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) do_hit($urandom, {$urandom, $urandom, $urandom, $urandom});

    w = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_miss(32'h0000_0200, w, 0, -1);
    chk("miss_line_const", build_line(w), 128'h0000000D_0000000C_0000000B_0000000A);

    for (int k = 0; k < 4; k++) w[k] = $urandom;
    do_miss(32'h0000_0348, w, 0, 2);
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    do_miss(32'h0000_0400, w, 5, -1);
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    do_miss(32'hFFFF_FFF4, w, 1, -1);
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    do_miss($urandom, w, 0, 3);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      do_miss($urandom, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)) - 1);
    end

    pc_in = 32'h0000_0300; ifq_ready = 1'b0; bus.cache_hit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("noready_busy", busy, 1'b0);
      chk("noready_dv", d_out_valid, 1'b0);
    end

    ifq_ready = 1'b1; flush = 1'b1;
    step();
    chk_quiet("flush_idle");

    flush = 1'b0; bus.cache_hit = 1'b1;
    step();
    ifq_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_lookup_hit_dv", d_out_valid, 1'b0);
    step();
    flush = 1'b0;
    chk_quiet("flush_lookup_hit_after");

    ifq_ready = 1'b1; bus.cache_hit = 1'b0;
    step();
    ifq_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk_quiet("flush_lookup_miss_after");
    step();
    chk_quiet("flush_lookup_miss_after2");

    pc_in = 32'h0000_0520; ifq_ready = 1'b1; bus.cache_hit = 1'b0;
    step();
    ifq_ready = 1'b0;
    step();
    bus.mem_ack = 1'b1; bus.mem_data = 32'h1111_1111;
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("rst_refill_beat1_addr", bus.mem_addr, 32'h0000_0524);
    rst = 1'b1;
    #1;
    chk_quiet("rst_refill_during");
    step();
    rst = 1'b0;
    #1;
    chk_quiet("rst_refill_after");
    chk("rst_refill_d_out", d_out, '0);
    chk("rst_refill_cache_addr", bus.cache_addr, '0);
    bus.mem_ack = 1'b1; bus.mem_data = 32'h2222_2222;
    step();
    bus.mem_ack = 1'b0;
    chk_quiet("stray_ack");
    chk("stray_ack_d_out", d_out, '0);

    for (int k = 0; k < 4; k++) w[k] = $urandom;
    do_miss(32'h0000_0524, w, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
